// File: rtl/als_sample_avg_if.sv
// als_sample_avg_if: conversion request/response handshake between the averager and the SPI light-sensor master
interface als_sample_avg_if #(
    parameter int W = 8
);
    logic         spi_valid;
    logic         spi_ready;
    logic [W-1:0] spi_data;
    modport master(output spi_valid, input spi_ready, input spi_data);
    modport slave(input spi_valid, output spi_ready, output spi_data);
endinterface

// File: rtl/als_sample_avg.sv
// als_sample_avg: periodic SPI sample acquisition with moving-window average and running min/max
module als_sample_avg #(
    parameter int SAMPLE_W = 8,
    parameter int LOG2_WIN = 3,
    parameter int PERIOD   = 100000,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clr_err,
    als_sample_avg_if.master    spi,
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                avg_valid,
    output logic [SAMPLE_W-1:0] min_out,
    output logic [SAMPLE_W-1:0] max_out,
    output logic [15:0]         sample_cnt,
    output logic                timeout_err
);
    localparam int WIN   = 1 << LOG2_WIN;
    localparam int SUM_W = SAMPLE_W + LOG2_WIN;
    localparam int PW    = $clog2(PERIOD);
    localparam int TW    = $clog2(TIMEOUT);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, REQ, RELEASE, UPDATE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       per_q, per_d;
    logic [TW-1:0]       to_q, to_d;
    logic [SAMPLE_W-1:0] smp_q, smp_d;
    logic                got_q, got_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [LOG2_WIN:0]   fill_q, fill_d;
    logic [LOG2_WIN-1:0] ptr_q, ptr_d;
    logic [SAMPLE_W-1:0] min_q, min_d, max_q, max_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] avg_q, avg_d;
    logic                avgv_q, avgv_d;
    logic                err_q, err_d;
    logic                set_err;
    logic [SAMPLE_W-1:0] buf_q [WIN];
    logic                full;
    logic [SUM_W-1:0]    new_sum;

    // fill saturates at exactly WIN, so its top bit alone marks a full window
    assign full    = fill_q[LOG2_WIN];
    assign new_sum = sum_q - SUM_W'(full ? buf_q[ptr_q] : '0) + SUM_W'(smp_q);

    always_comb begin
        state_d = state_q;
        per_d   = '0;
        to_d    = '0;
        smp_d   = smp_q;
        got_d   = got_q;
        sum_d   = sum_q;
        fill_d  = fill_q;
        ptr_d   = ptr_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        avg_d   = avg_q;
        avgv_d  = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE: if (enable) begin
                sum_d   = '0;
                fill_d  = '0;
                ptr_d   = '0;
                min_d   = '0;
                max_d   = '0;
                cnt_d   = '0;
                state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                per_d   = per_q + 1'b1;
                state_d = !enable ? IDLE : (per_q == PER_LAST) ? REQ : WAIT_TICK;
            end
            REQ: begin
                to_d = to_q + 1'b1;
                if (spi.spi_ready) begin
                    smp_d   = spi.spi_data;
                    got_d   = 1'b1;
                    state_d = RELEASE;
                end else if (to_q == TO_LAST) begin
                    set_err = 1'b1;
                    got_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: if (!spi.spi_ready) state_d = got_q ? UPDATE : enable ? WAIT_TICK : IDLE;
            UPDATE: begin
                sum_d   = new_sum;
                ptr_d   = ptr_q + 1'b1;
                fill_d  = full ? fill_q : fill_q + 1'b1;
                cnt_d   = cnt_q + 16'd1;
                min_d   = (fill_q == '0 || smp_q < min_q) ? smp_q : min_q;
                max_d   = (fill_q == '0 || smp_q > max_q) ? smp_q : max_q;
                avgv_d  = fill_d[LOG2_WIN];
                avg_d   = fill_d[LOG2_WIN] ? SAMPLE_W'(new_sum >> LOG2_WIN) : avg_q;
                state_d = enable ? WAIT_TICK : IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = set_err | (err_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            to_q    <= '0;
            smp_q   <= '0;
            got_q   <= 1'b0;
            sum_q   <= '0;
            fill_q  <= '0;
            ptr_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            avgv_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < WIN; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            to_q    <= to_d;
            smp_q   <= smp_d;
            got_q   <= got_d;
            sum_q   <= sum_d;
            fill_q  <= fill_d;
            ptr_q   <= ptr_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            avg_q   <= avg_d;
            avgv_q  <= avgv_d;
            err_q   <= err_d;
            if (state_q == UPDATE) buf_q[ptr_q] <= smp_q;
        end
    end

    assign spi.spi_valid = (state_q == REQ);
    assign avg_out       = avg_q;
    assign avg_valid     = avgv_q;
    assign min_out       = min_q;
    assign max_out       = max_q;
    assign sample_cnt    = cnt_q;
    assign timeout_err   = err_q;
endmodule

// File: tb/tb_als_sample_avg.sv
// tb_als_sample_avg: SPI-master stand-in with a queue-based window model checking avg/min/max/count/timeout
module tb_als_sample_avg;
    localparam int L = 2, WIN = 4, PER = 4, TMO = 16;

    logic clk = 1'b0;
    logic rst, enable, clr_err;
    logic [7:0] avg_out, min_out, max_out;
    logic avg_valid, timeout_err;
    logic [15:0] sample_cnt;
    int n_cmp = 0, n_bad = 0;
    int smp[$];
    int exp_avg = 0, exp_err = 0;

    always #5 clk = ~clk;

    als_sample_avg_if #(.W(8)) ifc();

    als_sample_avg #(.SAMPLE_W(8), .LOG2_WIN(L), .PERIOD(PER), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err), .spi(ifc.master),
        .avg_out(avg_out), .avg_valid(avg_valid), .min_out(min_out), .max_out(max_out),
        .sample_cnt(sample_cnt), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_min();
        int r;
        if (smp.size() == 0) return 0;
        r = smp[0];
        foreach (smp[i]) if (smp[i] < r) r = smp[i];
        return r;
    endfunction

    function automatic int m_max();
        int r = 0;
        foreach (smp[i]) if (smp[i] > r) r = smp[i];
        return r;
    endfunction

    function automatic int m_avg();
        int s = 0;
        for (int i = smp.size() - WIN; i < smp.size(); i++) s += smp[i];
        return s / WIN;
    endfunction

    task automatic wait_valid(input logic lvl, output int n);
        n = 0;
        while (ifc.spi_valid !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wait_spi_valid", ifc.spi_valid, lvl);
    endtask

    task automatic check_all(input int exp_v);
        chk("avg_valid", avg_valid, exp_v);
        chk("avg_out", avg_out, exp_avg);
        chk("min_out", min_out, m_min());
        chk("max_out", max_out, m_max());
        chk("sample_cnt", sample_cnt, smp.size() & 16'hffff);
        chk("timeout_err", timeout_err, exp_err);
    endtask

    // pre: raise ready before the request appears; drop_en: drop enable once the request is seen
    task automatic do_frame(input logic [7:0] d, input bit pre, input bit drop_en);
        int n;
        int lat = $urandom_range(0, 5);
        if (pre) begin
            ifc.spi_ready = 1'b1;
            ifc.spi_data  = d;
        end
        wait_valid(1'b1, n);
        if (drop_en) enable = 1'b0;
        if (!pre) begin
            repeat (lat) @(negedge clk);
            ifc.spi_ready = 1'b1;
            ifc.spi_data  = d;
        end
        wait_valid(1'b0, n);
        chk("req_after_ready", n, 1);
        ifc.spi_ready = 1'b0;
        ifc.spi_data  = 8'($urandom);
        smp.push_back(int'(d));
        if (smp.size() >= WIN) exp_avg = m_avg();
        repeat (2) @(negedge clk);
        check_all(int'(smp.size() >= WIN));
        @(negedge clk);
        chk("avg_valid_pulse", avg_valid, 0);
    endtask

    task automatic tmo_req(input bit coinc);
        int n;
        int hi = 0;
        wait_valid(1'b1, n);
        while (ifc.spi_valid && hi < 100) begin
            hi++;
            if (coinc && hi == TMO) clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
        end
        exp_err = 1;
        chk("tmo_len", hi, TMO);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_cnt", sample_cnt, smp.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, lows, hi;
        rst = 1'b1; enable = 1'b0; clr_err = 1'b0;
        ifc.spi_ready = 1'b0; ifc.spi_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_spi_valid", ifc.spi_valid, 0);
        check_all(0);
        rst = 1'b0;
        enable = 1'b1;
        do_frame(8'h10, 0, 0);
        do_frame(8'h20, 0, 0);
        do_frame(8'h30, 0, 0);
        do_frame(8'h40, 0, 0);
        chk("t1_avg", avg_out, 'h28);
        chk("t1_cnt", sample_cnt, 4);
        do_frame(8'h80, 0, 0);
        chk("t2_avg", avg_out, 'h44);
        chk("t2_max", max_out, 'h80);
        repeat (4) do_frame(8'hff, 0, 0);
        chk("t3_avg", avg_out, 'hff);
        repeat (20) do_frame(8'($urandom), 1'($urandom), 0);
        tmo_req(0);
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        chk("clr_err", timeout_err, 0);
        tmo_req(1);
        wait_valid(1'b1, n);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req_valid", ifc.spi_valid, 0);
        smp.delete();
        exp_avg = 0;
        exp_err = 0;
        check_all(0);
        lows = 0;
        while (!ifc.spi_valid && lows < 100) begin
            @(negedge clk);
            lows++;
        end
        // one IDLE cycle to leave reset, then PERIOD ticks before the request
        chk("rst_first_req", lows, PER + 1);
        do_frame(8'($urandom), 0, 0);
        repeat (4) do_frame(8'($urandom), 1'($urandom), 0);
        do_frame(8'($urandom), 0, 1);
        hi = 0;
        repeat (3 * PER) begin
            @(negedge clk);
            if (ifc.spi_valid) hi++;
        end
        chk("idle_no_req", hi, 0);
        enable = 1'b1;
        smp.delete();
        @(negedge clk);
        chk("reen_cnt", sample_cnt, 0);
        chk("reen_avg_hold", avg_out, exp_avg);
        repeat (5) do_frame(8'($urandom), 1'($urandom), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
